// File: rtl/nand_xnor_cmp_if.sv
// Handshake and operand/result bundle for the sliced NAND-XNOR comparator.
interface nand_xnor_cmp_if #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] xnor_out;
  logic [CW-1:0]    match_cnt;
  logic             eq;

  modport master (
    output start, a, b,
    input  busy, done, xnor_out, match_cnt, eq
  );

  modport slave (
    input  start, a, b,
    output busy, done, xnor_out, match_cnt, eq
  );
endinterface

// File: rtl/nand_xnor_cmp.sv
// Multi-cycle XNOR comparator: SLICE bits per clock through NAND-only XNOR cells,
// yielding the XNOR vector, a match count and an equality flag.
module nand_xnor_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n1, n2, n3, x;

  // Classic four-NAND XOR, inverted by a fifth NAND wired as an inverter.
  assign n1 = ~(a & b);
  assign n2 = ~(a & n1);
  assign n3 = ~(b & n1);
  assign x  = ~(n2 & n3);
  assign y  = ~(x & x);
endmodule

module nand_xnor_cmp #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic           clk,
  input logic           rst,
  nand_xnor_cmp_if.slave bus
);
  localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("nand_xnor_cmp: WIDTH must be >= 1 and divisible by SLICE");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_next;
  logic [CW-1:0]    cnt, cnt_next, slice_cnt;
  logic [IW-1:0]    idx;
  logic [SLICE-1:0] slice_a, slice_b, slice_x;
  logic             last;
  logic             done_r, eq_r;
  logic [WIDTH-1:0] xnor_r;
  logic [CW-1:0]    match_r;

  for (genvar g = 0; g < SLICE; g++) begin : g_cells
    nand_xnor_cell u_cell (
      .a (slice_a[g]),
      .b (slice_b[g]),
      .y (slice_x[g])
    );
  end

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (idx == IW'(j)) begin
        slice_a = a_reg[j*SLICE +: SLICE];
        slice_b = b_reg[j*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    acc_next  = acc;
    slice_cnt = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (idx == IW'(j)) acc_next[j*SLICE +: SLICE] = slice_x;
    end
    for (int unsigned j = 0; j < SLICE; j++) begin
      slice_cnt = slice_cnt + CW'(slice_x[j]);
    end
    cnt_next = cnt + slice_cnt;
    last     = (idx == IW'(N - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      idx     <= '0;
      done_r  <= 1'b0;
      xnor_r  <= '0;
      match_r <= '0;
      eq_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt_next;
          if (last) begin
            // Results take the final slice straight from the cells, not from acc.
            xnor_r  <= acc_next;
            match_r <= cnt_next;
            eq_r    <= (cnt_next == CW'(WIDTH));
            done_r  <= 1'b1;
            idx     <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = done_r;
  assign bus.xnor_out  = xnor_r;
  assign bus.match_cnt = match_r;
  assign bus.eq        = eq_r;
endmodule
